// File: rtl/rf_write_arbiter_pkg.sv
// Shared CPU types for the register-file write arbiter: word/register widths and arbiter states.
package cpu_types_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCED = 1'b1
  } arb_state_t;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback request bundle: PIPE and MC handshakes plus the MC register claim.
interface rf_write_arbiter_if;
  import cpu_types_pkg::*;

  logic     pipe_valid;
  logic     pipe_ready;
  regbits_t pipe_wsel;
  word_t    pipe_wdat;
  logic     mc_valid;
  logic     mc_ready;
  regbits_t mc_wsel;
  word_t    mc_wdat;
  logic     mc_claim;
  regbits_t mc_claim_sel;

  modport master (
    output pipe_valid, pipe_wsel, pipe_wdat,
    output mc_valid, mc_wsel, mc_wdat, mc_claim, mc_claim_sel,
    input  pipe_ready, mc_ready
  );

  modport slave (
    input  pipe_valid, pipe_wsel, pipe_wdat,
    input  mc_valid, mc_wsel, mc_wdat, mc_claim, mc_claim_sel,
    output pipe_ready, mc_ready
  );
endinterface

// File: rtl/rf_write_arbiter_scoreboard.sv
// rf_scoreboard: per-register outstanding-MC-write flags and decode read-hazard lookup.
module rf_scoreboard
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     RST,
  input  logic     claim,
  input  regbits_t claim_sel,
  input  logic     clr,
  input  regbits_t clr_sel,
  input  regbits_t rsel1,
  input  regbits_t rsel2,
  output word_t    busy,
  output logic     hazard
);
  word_t busy_n;

  // Clear first so a same-cycle claim of the same register wins.
  always_comb begin
    busy_n = busy;
    if (clr)
      busy_n[clr_sel] = 1'b0;
    if (claim && (claim_sel != '0))
      busy_n[claim_sel] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      busy <= '0;
    else
      busy <= busy_n;
  end

  assign hazard = busy[rsel1] | busy[rsel2];
endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: PIPE priority with MC aging, registered write port.
// Optional scoreboard enabled by defining RF_ARB_SCOREBOARD_EN.
module rf_write_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic     CLK,
  input  logic     RST,
  rf_write_arbiter_if.slave req,
  input  regbits_t rsel1,
  input  regbits_t rsel2,
  output logic     hazard,
  output word_t    busy,
  output logic     WEN,
  output regbits_t wsel,
  output word_t    wdat
);
  arb_state_t arb_state, arb_state_n;
  logic [3:0] age;
  logic       pipe_xfer, mc_xfer;
  regbits_t   win_sel;
  word_t      win_dat;

  // Ready is held at its reset-safe value while RST is high.
  always_comb begin
    req.pipe_ready = 1'b1;
    req.mc_ready   = 1'b0;
    if (!RST) begin
      if (arb_state == FORCED) begin
        req.pipe_ready = 1'b0;
        req.mc_ready   = 1'b1;
      end else begin
        req.mc_ready   = !req.pipe_valid;
      end
    end
  end

  assign pipe_xfer = req.pipe_valid && req.pipe_ready;
  assign mc_xfer   = req.mc_valid && req.mc_ready;
  assign win_sel   = mc_xfer ? req.mc_wsel : req.pipe_wsel;
  assign win_dat   = mc_xfer ? req.mc_wdat : req.pipe_wdat;

  always_comb begin
    arb_state_n = arb_state;
    case (arb_state)
      NORMAL: if (req.mc_valid && !req.mc_ready && (age == 4'(STARVE_MAX - 1)))
                arb_state_n = FORCED;
      FORCED: if (mc_xfer)
                arb_state_n = NORMAL;
      default: arb_state_n = NORMAL;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      arb_state <= NORMAL;
      age       <= '0;
    end else begin
      arb_state <= arb_state_n;
      if (!req.mc_valid || mc_xfer)
        age <= '0;
      else if (age < 4'(STARVE_MAX))
        age <= age + 4'd1;
    end
  end

  // Write-port stage: one cycle after the transfer; register 0 never gets WEN.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      WEN  <= 1'b0;
      wsel <= '0;
      wdat <= '0;
    end else begin
      WEN <= (pipe_xfer || mc_xfer) && (win_sel != '0);
      if (pipe_xfer || mc_xfer) begin
        wsel <= win_sel;
        wdat <= win_dat;
      end
    end
  end

`ifdef RF_ARB_SCOREBOARD_EN
  rf_scoreboard u_scoreboard (
    .CLK       (CLK),
    .RST       (RST),
    .claim     (req.mc_claim),
    .claim_sel (req.mc_claim_sel),
    .clr       (mc_xfer),
    .clr_sel   (req.mc_wsel),
    .rsel1     (rsel1),
    .rsel2     (rsel2),
    .busy      (busy),
    .hazard    (hazard)
  );
`else
  logic unused_sb;
  assign unused_sb = ^{req.mc_claim, req.mc_claim_sel, rsel1, rsel2};
  assign busy      = '0;
  assign hazard    = 1'b0;
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter; scoreboard steps follow RF_ARB_SCOREBOARD_EN.
module tb_rf_write_arbiter;
  import cpu_types_pkg::*;

  logic     CLK = 1'b0;
  logic     RST;
  regbits_t rsel1, rsel2;
  logic     hazard;
  word_t    busy;
  logic     WEN;
  regbits_t wsel;
  word_t    wdat;
  int       n_run  = 0;
  int       n_fail = 0;

  always #5 CLK = ~CLK;

  rf_write_arbiter_if bus ();

  rf_write_arbiter #(.STARVE_MAX(4)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .req    (bus.slave),
    .rsel1  (rsel1),
    .rsel2  (rsel2),
    .hazard (hazard),
    .busy   (busy),
    .WEN    (WEN),
    .wsel   (wsel),
    .wdat   (wdat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    bus.pipe_valid = 0; bus.pipe_wsel = '0; bus.pipe_wdat = '0;
    bus.mc_valid   = 1; bus.mc_wsel   = '0; bus.mc_wdat   = '0;
    bus.mc_claim   = 0; bus.mc_claim_sel = '0;
    rsel1 = '0; rsel2 = '0;
    #1;
    chk("rst_pipe_ready", bus.pipe_ready, 1);
    chk("rst_mc_ready", bus.mc_ready, 0);
    bus.mc_valid = 0;
    tick(); tick();
    RST = 1'b0;
    #1;
    chk("idle_wen", WEN, 0);
    chk("idle_wsel", wsel, 0);
    chk("idle_wdat", wdat, 0);
    chk("idle_busy", busy, 0);
    chk("idle_hazard", hazard, 0);
    chk("idle_pipe_ready", bus.pipe_ready, 1);
    tick();
    chk("idle_wen2", WEN, 0);

    // single PIPE transfer
    bus.pipe_valid = 1; bus.pipe_wsel = 5'd5; bus.pipe_wdat = 32'hDEADBEEF;
    #1;
    chk("single_ready", bus.pipe_ready, 1);
    tick();
    bus.pipe_valid = 0;
    chk("single_wen", WEN, 1);
    chk("single_wsel", wsel, 5);
    chk("single_wdat", wdat, 32'hDEADBEEF);
    tick();
    chk("single_wen_off", WEN, 0);
    chk("single_wsel_hold", wsel, 5);

    // concurrent requests: MC refused 4 cycles, forced on the 5th
    bus.pipe_valid = 1; bus.pipe_wsel = 5'd3; bus.pipe_wdat = 32'h11111111;
    bus.mc_valid   = 1; bus.mc_wsel   = 5'd9; bus.mc_wdat   = 32'h99999999;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("conc_mc_refused", bus.mc_ready, 0);
      chk("conc_pipe_ready", bus.pipe_ready, 1);
      tick();
      chk("conc_pipe_wen", WEN, 1);
      chk("conc_pipe_wsel", wsel, 3);
    end
    chk("conc_forced_mc_ready", bus.mc_ready, 1);
    chk("conc_forced_pipe_stall", bus.pipe_ready, 0);
    tick();
    bus.mc_valid = 0;
    chk("conc_mc_wen", WEN, 1);
    chk("conc_mc_wsel", wsel, 9);
    chk("conc_mc_wdat", wdat, 32'h99999999);
    chk("conc_age_clear", dut.age, 0);
    #1;
    chk("conc_pipe_resume", bus.pipe_ready, 1);
    tick();
    bus.pipe_valid = 0;
    chk("conc_pipe_b2b_wen", WEN, 1);
    chk("conc_pipe_b2b_wsel", wsel, 3);

    // MC write to register 0
    bus.mc_valid = 1; bus.mc_wsel = 5'd0; bus.mc_wdat = 32'hCAFEF00D;
    #1;
    chk("r0_mc_ready", bus.mc_ready, 1);
    tick();
    bus.mc_valid = 0;
    chk("r0_wen", WEN, 0);

    // scoreboard
    bus.mc_claim = 1; bus.mc_claim_sel = 5'd7; rsel1 = 5'd7; rsel2 = 5'd2;
    tick();
    bus.mc_claim = 0;
`ifdef RF_ARB_SCOREBOARD_EN
    chk("sb_claim_busy", busy, 32'h0000_0080);
    chk("sb_claim_hazard", hazard, 1);
    bus.mc_valid = 1; bus.mc_wsel = 5'd7; bus.mc_wdat = 32'h00000077;
    #1;
    chk("sb_hazard_during_xfer", hazard, 1);
    tick();
    bus.mc_valid = 0;
    chk("sb_clear_busy", busy, 0);
    chk("sb_clear_hazard", hazard, 0);
    chk("sb_write_wen", WEN, 1);
    bus.mc_claim = 1; bus.mc_claim_sel = 5'd7;
    bus.mc_valid = 1; bus.mc_wsel = 5'd7;
    tick();
    bus.mc_claim = 0; bus.mc_valid = 0;
    chk("sb_set_wins", busy, 32'h0000_0080);
    bus.mc_claim = 1; bus.mc_claim_sel = 5'd0;
    tick();
    bus.mc_claim = 0;
    chk("sb_r0_ignored", busy, 32'h0000_0080);
`else
    chk("nosb_busy", busy, 0);
    chk("nosb_hazard", hazard, 0);
`endif

    // reset asserted the cycle after a transfer
    bus.pipe_valid = 1; bus.pipe_wsel = 5'd12; bus.pipe_wdat = 32'h12345678;
    bus.mc_valid = 1; bus.mc_wsel = 5'd4;
    tick();
    chk("rstmid_wen_before", WEN, 1);
    chk("rstmid_age_before", dut.age, 1);
    RST = 1'b1;
    #1;
    chk("rstmid_wen", WEN, 0);
    chk("rstmid_age", dut.age, 0);
    chk("rstmid_busy", busy, 0);
    bus.pipe_valid = 0; bus.mc_valid = 0;
    tick();
    RST = 1'b0;
    tick();
    chk("rstmid_no_pulse", WEN, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
